// File: rtl/time_set_ctrl_if.sv
// Bundle between button front-end / clock core and time_set_ctrl.
// master drives buttons and current digits; slave is the setter.
interface time_set_ctrl_if;
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_dec;
  logic [3:0]  cur_hr_10s;
  logic [3:0]  cur_hr_1s;
  logic [3:0]  cur_min_10s;
  logic [3:0]  cur_min_1s;
  logic [3:0]  cur_sec_10s;
  logic [3:0]  cur_sec_1s;
  logic [16:0] time_out;
  logic        time_ow;
  logic        editing;
  logic [1:0]  edit_field;
  logic [5:0]  edit_value;

  modport master (
    output btn_mode, btn_inc, btn_dec,
    output cur_hr_10s, cur_hr_1s,
    output cur_min_10s, cur_min_1s,
    output cur_sec_10s, cur_sec_1s,
    input  time_out, time_ow,
    input  editing, edit_field, edit_value
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec,
    input  cur_hr_10s, cur_hr_1s,
    input  cur_min_10s, cur_min_1s,
    input  cur_sec_10s, cur_sec_1s,
    output time_out, time_ow,
    output editing, edit_field, edit_value
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-set controller: button-driven hh:mm:ss editor for the clock.
// Optional macro TIME_SET_TIMEOUT_EN abandons idle edits.
module time_set_ctrl #(
  parameter int OW_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic           clk,
  input logic           rst,
  time_set_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT
  } state_t;

  localparam int OW_W =
    (OW_CYCLES > 1) ? $clog2(OW_CYCLES) : 1;

  state_t      state, state_nxt;
  logic [4:0]  hr_reg, hr_nxt;
  logic [5:0]  min_reg, min_nxt;
  logic [5:0]  sec_reg, sec_nxt;
  logic [16:0] out_reg, out_nxt;
  logic        ow_reg, ow_nxt;
  logic [OW_W-1:0] ow_cnt, ow_cnt_nxt;
  logic        edt_reg, edt_nxt;
  logic [1:0]  fld_reg, fld_nxt;
  logic [5:0]  val_reg, val_nxt;

  logic [5:0]  hr_cap, min_cap, sec_cap;
  logic [5:0]  hr_stp, min_stp, sec_stp;
  logic        any_btn;

  function automatic logic [5:0] bcd2bin(
    input logic [3:0] t,
    input logic [3:0] o,
    input logic [7:0] max
  );
    logic [7:0] b;
    b = ({4'd0, t} * 8'd10) + {4'd0, o};
    if (t > 4'd9 || o > 4'd9 || b > max)
      bcd2bin = 6'd0;
    else
      bcd2bin = b[5:0];
  endfunction

  function automatic logic [5:0] step(
    input logic [5:0] v,
    input logic [5:0] max,
    input logic       up,
    input logic       dn
  );
    if (up && !dn)
      step = (v >= max) ? 6'd0 : v + 6'd1;
    else if (dn && !up)
      step = (v == 6'd0) ? max : v - 6'd1;
    else
      step = v;
  endfunction

  assign hr_cap  = bcd2bin(bus.cur_hr_10s,
                           bus.cur_hr_1s, 8'd23);
  assign min_cap = bcd2bin(bus.cur_min_10s,
                           bus.cur_min_1s, 8'd59);
  assign sec_cap = bcd2bin(bus.cur_sec_10s,
                           bus.cur_sec_1s, 8'd59);

  assign hr_stp  = step({1'b0, hr_reg}, 6'd23,
                        bus.btn_inc, bus.btn_dec);
  assign min_stp = step(min_reg, 6'd59,
                        bus.btn_inc, bus.btn_dec);
  assign sec_stp = step(sec_reg, 6'd59,
                        bus.btn_inc, bus.btn_dec);

  assign any_btn = bus.btn_mode | bus.btn_inc
                 | bus.btn_dec;

  logic unused_bits;
  assign unused_bits = ^{hr_cap[5], hr_stp[5]};

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          tmo_hit;
  logic          in_edit;

  assign in_edit = (state == EDIT_HR)
                || (state == EDIT_MIN)
                || (state == EDIT_SEC);
  assign tmo_hit = in_edit && !any_btn
    && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle-edit counter; restarts on any button.
  always_comb begin
    tmo_nxt = '0;
    if (in_edit && !any_btn && !tmo_hit)
      tmo_nxt = tmo_cnt + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_cnt <= '0;
    else     tmo_cnt <= tmo_nxt;
  end
`else
  logic tmo_hit;
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES > 0) ^ any_btn;
`endif

  // Next state, field registers and registered outputs.
  always_comb begin
    state_nxt  = state;
    hr_nxt     = hr_reg;
    min_nxt    = min_reg;
    sec_nxt    = sec_reg;
    out_nxt    = out_reg;
    ow_nxt     = 1'b0;
    ow_cnt_nxt = '0;
    fld_nxt    = 2'd0;
    val_nxt    = 6'd0;
    edt_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.btn_mode) begin
          hr_nxt    = hr_cap[4:0];
          min_nxt   = min_cap;
          sec_nxt   = sec_cap;
          state_nxt = EDIT_HR;
        end
      end
      EDIT_HR: begin
        if (bus.btn_mode) state_nxt = EDIT_MIN;
        else              hr_nxt = hr_stp[4:0];
      end
      EDIT_MIN: begin
        if (bus.btn_mode) state_nxt = EDIT_SEC;
        else              min_nxt = min_stp;
      end
      EDIT_SEC: begin
        if (bus.btn_mode) begin
          state_nxt = COMMIT;
          out_nxt   = {hr_reg, min_reg, sec_reg};
          ow_nxt    = 1'b1;
        end else begin
          sec_nxt = sec_stp;
        end
      end
      COMMIT: begin
        if (ow_cnt == OW_W'(OW_CYCLES - 1)) begin
          state_nxt = IDLE;
        end else begin
          ow_nxt     = 1'b1;
          ow_cnt_nxt = ow_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (tmo_hit) state_nxt = IDLE;

    unique case (state_nxt)
      EDIT_HR: begin
        fld_nxt = 2'd1;
        val_nxt = {1'b0, hr_nxt};
      end
      EDIT_MIN: begin
        fld_nxt = 2'd2;
        val_nxt = min_nxt;
      end
      EDIT_SEC: begin
        fld_nxt = 2'd3;
        val_nxt = sec_nxt;
      end
      default: begin
        fld_nxt = 2'd0;
        val_nxt = 6'd0;
      end
    endcase
    edt_nxt = (fld_nxt != 2'd0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hr_reg  <= '0;
      min_reg <= '0;
      sec_reg <= '0;
      out_reg <= '0;
      ow_reg  <= 1'b0;
      ow_cnt  <= '0;
      edt_reg <= 1'b0;
      fld_reg <= '0;
      val_reg <= '0;
    end else begin
      state   <= state_nxt;
      hr_reg  <= hr_nxt;
      min_reg <= min_nxt;
      sec_reg <= sec_nxt;
      out_reg <= out_nxt;
      ow_reg  <= ow_nxt;
      ow_cnt  <= ow_cnt_nxt;
      edt_reg <= edt_nxt;
      fld_reg <= fld_nxt;
      val_reg <= val_nxt;
    end
  end

  assign bus.time_out   = out_reg;
  assign bus.time_ow    = ow_reg;
  assign bus.editing    = edt_reg;
  assign bus.edit_field = fld_reg;
  assign bus.edit_value = val_reg;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

- Writes a new time into the digital clock from user button pulses.
- On entry, loads the clock's current BCD display digits, converts them to binary and lets the user adjust hours, minutes and seconds in turn.
- On commit, drives the packed 17-bit time word (hhhhh:mmmmmm:ssssss) and a `time_ow` overwrite pulse into the clock's `time_in`/`time_ow` inputs.
- Sits between the debounced button front-end and the clock core.

## Interface
- `OW_CYCLES`, default 2: width of the `time_ow` pulse in clk cycles; legal range ≥1.
- `TIMEOUT_CYCLES`, default 1000: number of idle cycles before an edit is abandoned; used only with `TIME_SET_TIMEOUT_EN`.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `btn_mode` in 1: single-cycle pulse; enter edit, or advance to the next field.
- `btn_inc` in 1: single-cycle pulse; increment the active field.
- `btn_dec` in 1: single-cycle pulse; decrement the active field.
- `cur_hr_10s`, `cur_hr_1s`, `cur_min_10s`, `cur_min_1s`, `cur_sec_10s`, `cur_sec_1s` in 4 each: current BCD time from the clock.
- `time_out` out 17: packed `{hour[4:0], min[5:0], sec[5:0]}`; connects to the clock's `time_in`.
- `time_ow` out 1: overwrite strobe; connects to the clock's `time_ow`.
- `editing` out 1: high while in any EDIT state.
- `edit_field` out 2: 0 = none, 1 = hour, 2 = minute, 3 = second.
- `edit_value` out 6: binary value of the active field, zero-extended; 0 when not editing.

## Operation
- State machine: IDLE → EDIT_HR → EDIT_MIN → EDIT_SEC → COMMIT → IDLE.
- **IDLE:**
  - `btn_mode` captures all six `cur_*` digits.
  - Converts each field as tens×10 + ones, into hr_reg (5b), min_reg (6b) and sec_reg (6b).
  - Then enters EDIT_HR.
- **Capture validation, per field:**
  - If either digit is >9, or hour >23, or min/sec >59, that field loads 0.
  - Other fields are unaffected.
- **EDIT_x states:**
  - `btn_inc`: +1, wrapping at the maximum to 0. Hour maximum is 23; minute/second maximum is 59.
  - `btn_dec`: −1, wrapping 0 to the maximum.
  - `btn_inc` and `btn_dec` in the same cycle: no change.
  - `btn_mode` advances to the next state. If `btn_mode` coincides with inc/dec, mode wins and inc/dec is ignored.
- **EDIT_SEC + `btn_mode`:** enters COMMIT.
- **COMMIT:**
  - `time_out` is loaded with `{hr_reg, min_reg, sec_reg}`.
  - `time_ow` is high for exactly `OW_CYCLES` cycles, then the block returns to IDLE.
  - All buttons are ignored in COMMIT.
- **`time_out` hold:** holds the last committed value indefinitely; it changes only on entry to COMMIT.
- **Reset:** `rst` in any state, including mid-edit or mid-COMMIT, returns to IDLE with no commit. Reset values:
  - state IDLE
  - `time_out` = 0, `time_ow` = 0
  - `editing` = 0, `edit_field` = 0, `edit_value` = 0
  - hr_reg, min_reg, sec_reg = 0
  - timeout counter = 0
  - An in-progress `time_ow` pulse is cut short immediately.

## Timing
- All outputs are registered.
- `btn_mode` sampled in IDLE at edge N → `editing` = 1, `edit_field` = 1 and `edit_value` = captured hour, all visible after edge N.
- inc/dec at edge N → `edit_value` updated after edge N (1-cycle latency).
- `btn_mode` in EDIT_SEC at edge N:
  - `time_ow` rises after edge N and falls after edge N+`OW_CYCLES`.
  - `time_out` is valid from the first `time_ow`-high cycle onward.
  - `editing` = 0 and `edit_field` = 0 from edge N onward.
- Next accepted `btn_mode`: at the first edge after `time_ow` falls.
- Buttons are assumed synchronous single-cycle pulses. Held levels are treated as one pulse per cycle.

## Configuration
- Macro: `TIME_SET_TIMEOUT_EN`.
- **Defined:**
  - A counter, ⌈log2(`TIMEOUT_CYCLES`+1)⌉ bits wide, clears on any button pulse and counts while in EDIT_x.
  - When it reaches `TIMEOUT_CYCLES`, the block returns to IDLE on that edge with no commit. `time_ow` stays 0 and `time_out` is unchanged.
- **Undefined:** no counter; EDIT states persist until `btn_mode` or `rst`.

## Test plan
- **Reset:** assert `rst` 2 cycles → `time_out`=0, `time_ow`=0, `editing`=0, `edit_field`=0. Then `btn_mode` with cur=12:34:56 → `edit_value`=12, `edit_field`=1.
- **Full edit:** cur=23:59:58. Sequence: mode, inc (hour→0), mode, dec (min→58), mode, inc ×2 (sec→0), mode. Required:
  - `time_out` = {5'd0, 6'd58, 6'd0}.
  - `time_ow` high exactly 2 cycles (`OW_CYCLES`=2).
  - Then IDLE.
- **Invalid capture:** cur=2 5:6 1:0 A (hour 25, min 61, sec digit 0xA) → after mode, each field reads 0 as it is visited.
- **Simultaneous inputs:**
  - inc+dec same cycle in EDIT_MIN at 30 → stays 30.
  - mode+inc same cycle in EDIT_HR → hour unchanged; state EDIT_MIN.
- **Reset mid-operation:** `rst` during the first `time_ow` cycle → `time_ow`=0 next cycle, `time_out`=0, state IDLE. `rst` during EDIT_SEC → no `time_ow` is ever emitted.
- **Timeout** (`TIME_SET_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): enter edit, no buttons for 8 cycles → `editing`=0, `time_ow` never high, `time_out` unchanged. Without the macro → still editing after 100 cycles.
